// File: rtl/arm_cu_pkg.sv
// arm_cu_pkg: shared LDM/STM sequencer state encodings, addressing modes and sizing constants
package arm_cu_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DONE = 2'd2} lsm_state_e;
    // Mode encoding is {P_BIT, U_BIT} straight from the instruction word
    typedef enum logic [1:0] {MODE_DA = 2'b00, MODE_IA = 2'b01, MODE_DB = 2'b10, MODE_IB = 2'b11} lsm_mode_e;
    localparam int LSM_WORD_BYTES = 4;
endpackage

// File: rtl/lsm_sequencer_if.sv
// lsm_sequencer_if: control-unit <-> LDM/STM sequencer bus; PC_IN_LIST exists only with LSM_PC_FLAG_EN
interface lsm_sequencer_if #(parameter int ADDR_W = 32);
    logic START;
    logic STEP;
    logic [15:0] REG_LIST;
    logic P_BIT;
    logic U_BIT;
    logic [ADDR_W-1:0] BASE;
    logic LSM_DETECT;
    logic LSM_END;
    logic [3:0] REG_NUM;
    logic [ADDR_W-1:0] ADDR;
    logic [ADDR_W-1:0] WB_ADDR;
    logic [4:0] COUNT;
    logic BUSY;
`ifdef LSM_PC_FLAG_EN
    logic PC_IN_LIST;
`endif
    modport master (
        output START, STEP, REG_LIST, P_BIT, U_BIT, BASE,
        input
`ifdef LSM_PC_FLAG_EN
        PC_IN_LIST,
`endif
        LSM_DETECT, LSM_END, REG_NUM, ADDR, WB_ADDR, COUNT, BUSY
    );
    modport slave (
        input START, STEP, REG_LIST, P_BIT, U_BIT, BASE,
        output
`ifdef LSM_PC_FLAG_EN
        PC_IN_LIST,
`endif
        LSM_DETECT, LSM_END, REG_NUM, ADDR, WB_ADDR, COUNT, BUSY
    );
endinterface

// File: rtl/lsm_prio_enc.sv
// lsm_prio_enc: index of the lowest set bit of a 16-bit vector, with valid
module lsm_prio_enc (
    input  logic [15:0] vec,
    output logic [3:0]  idx,
    output logic        valid
);
    always_comb begin
        idx = '0;
        valid = |vec;
        for (int i = 15; i >= 0; i--)
            if (vec[i]) idx = 4'(i);
    end
endmodule

// File: rtl/lsm_sequencer.sv
// lsm_sequencer: walks an LDM/STM register list lowest-first, issuing register number and ascending word address.
// Define LSM_PC_FLAG_EN to add PC_IN_LIST (R15 present in the latched list).
module lsm_sequencer
    import arm_cu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int WORD_BYTES = LSM_WORD_BYTES
) (
    input logic CLK,
    input logic RESET,
    lsm_sequencer_if.slave bus
);
    lsm_state_e state;
    lsm_mode_e mode;
    logic [15:0] pending, pending_next, enc_in;
    logic [4:0] cnt;
    logic [ADDR_W-1:0] span, wb, start;
    logic [3:0] enc_idx;
    logic enc_valid, last_next;
    assign mode = lsm_mode_e'({bus.P_BIT, bus.U_BIT});
    always_comb begin
        cnt = '0;
        for (int i = 0; i < 16; i++)
            cnt = cnt + 5'(bus.REG_LIST[i]);
        span = ADDR_W'(cnt) * ADDR_W'(WORD_BYTES);
        wb = bus.U_BIT ? bus.BASE + span : bus.BASE - span;
        start = mode == MODE_IA ? bus.BASE :
                mode == MODE_IB ? bus.BASE + ADDR_W'(WORD_BYTES) :
                mode == MODE_DB ? wb : wb + ADDR_W'(WORD_BYTES);
        pending_next = pending & ~(16'd1 << bus.REG_NUM);
        last_next = (pending_next != '0) && ((pending_next & (pending_next - 16'd1)) == '0);
        // In IDLE the encoder finds the first register; in ACTIVE, the one after the current
        enc_in = state == ACTIVE ? pending_next : bus.REG_LIST;
    end
    lsm_prio_enc u_enc (.vec(enc_in), .idx(enc_idx), .valid(enc_valid));
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            pending <= '0;
            bus.LSM_DETECT <= 1'b0;
            bus.LSM_END <= 1'b0;
            bus.REG_NUM <= '0;
            bus.ADDR <= '0;
            bus.WB_ADDR <= '0;
            bus.COUNT <= '0;
            bus.BUSY <= 1'b0;
`ifdef LSM_PC_FLAG_EN
            bus.PC_IN_LIST <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (bus.START) begin
                    pending <= bus.REG_LIST;
                    bus.COUNT <= cnt;
                    bus.ADDR <= start;
                    bus.WB_ADDR <= wb;
                    bus.BUSY <= 1'b1;
                    bus.LSM_DETECT <= cnt != '0;
                    // One register is both first and last; an empty list goes straight to DONE
                    bus.LSM_END <= cnt <= 5'd1;
                    if (enc_valid) bus.REG_NUM <= enc_idx;
                    state <= cnt != '0 ? ACTIVE : DONE;
`ifdef LSM_PC_FLAG_EN
                    bus.PC_IN_LIST <= bus.REG_LIST[15];
`endif
                end
                ACTIVE: if (bus.STEP) begin
                    pending <= pending_next;
                    bus.ADDR <= bus.ADDR + ADDR_W'(WORD_BYTES);
                    if (enc_valid) bus.REG_NUM <= enc_idx;
                    bus.LSM_DETECT <= !bus.LSM_END;
                    bus.LSM_END <= bus.LSM_END | last_next;
                    state <= bus.LSM_END ? DONE : ACTIVE;
                end
                DONE: begin
                    bus.LSM_END <= 1'b0;
                    bus.BUSY <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsm_sequencer.sv
// tb_lsm_sequencer: directed LDM/STM vectors; expected transfers are queued at issue and checked by a monitor
module tb_lsm_sequencer;
    logic CLK = 1'b0;
    logic RESET = 1'b1;
    int vectors = 0;
    int fails = 0;

    typedef struct {
        bit done;
        logic [3:0] r;
        logic [31:0] a;
        bit last;
        logic [31:0] wb;
        logic [4:0] n;
    } exp_t;
    exp_t q[$];

    lsm_sequencer_if #(.ADDR_W(32)) bus ();
    lsm_sequencer #(.ADDR_W(32), .WORD_BYTES(4)) dut (.CLK(CLK), .RESET(RESET), .bus(bus.slave));

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_detect"}, 32'(bus.LSM_DETECT), 0);
        chk({tag, "_end"}, 32'(bus.LSM_END), 0);
        chk({tag, "_regnum"}, 32'(bus.REG_NUM), 0);
        chk({tag, "_addr"}, bus.ADDR, 0);
        chk({tag, "_wb"}, bus.WB_ADDR, 0);
        chk({tag, "_count"}, 32'(bus.COUNT), 0);
        chk({tag, "_busy"}, 32'(bus.BUSY), 0);
    endtask

    task automatic do_seq(input logic [15:0] list, input logic [31:0] base, input logic p, input logic u,
                          input logic [31:0] start, input logic [31:0] wb, input int hold_at, input bit noise);
        int n = 0, k = 0, held = 0, guard = 0;
        exp_t e;
        for (int i = 0; i < 16; i++) n += int'(list[i]);
        for (int i = 0; i < 16; i++)
            if (list[i]) begin
                e.done = 0; e.r = 4'(i); e.a = start + 32'(4 * k); e.last = (k == n - 1);
                e.wb = wb; e.n = 5'(n);
                q.push_back(e);
                k++;
            end
        e.done = 1; e.r = 0; e.a = 0; e.last = 1; e.wb = wb; e.n = 5'(n);
        q.push_back(e);
        bus.REG_LIST = list; bus.BASE = base; bus.P_BIT = p; bus.U_BIT = u; bus.START = 1;
        tick();
        bus.START = 0;
        k = 0;
        while (bus.LSM_DETECT && guard < 200) begin
            if (k == hold_at && held < 3) begin
                bus.STEP = 0; held++;
            end else begin
                bus.STEP = 1; k++;
            end
            if (noise) begin
                bus.START = 1; bus.REG_LIST = ~list; bus.BASE = base + 32'h1000;
            end
            tick();
            guard++;
        end
        bus.STEP = 0; bus.START = 0; bus.REG_LIST = list; bus.BASE = base;
        while (bus.BUSY && guard < 200) begin
            tick();
            guard++;
        end
        chk("seq_terminates", 32'(guard < 200), 1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK);
            if (!RESET) begin
                if (bus.LSM_DETECT || bus.BUSY) begin
                    vectors++;
                    if (q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_output: detect=%b end=%b reg=%0d addr=%h, nothing expected",
                                 bus.LSM_DETECT, bus.LSM_END, bus.REG_NUM, bus.ADDR);
                    end else begin
                        e = q[0];
                        if (bus.LSM_DETECT) begin
                            if (e.done || !bus.BUSY || bus.REG_NUM !== e.r || bus.ADDR !== e.a
                                || bus.LSM_END !== e.last || bus.WB_ADDR !== e.wb) begin
                                fails++;
                                $display("FAIL transfer: got reg=%0d addr=%h end=%b wb=%h busy=%b expected done=%b reg=%0d addr=%h end=%b wb=%h",
                                         bus.REG_NUM, bus.ADDR, bus.LSM_END, bus.WB_ADDR, bus.BUSY,
                                         e.done, e.r, e.a, e.last, e.wb);
                            end
                            if (bus.STEP) void'(q.pop_front());
                        end else begin
                            if (!e.done || bus.LSM_END !== 1'b1 || bus.WB_ADDR !== e.wb || bus.COUNT !== e.n) begin
                                fails++;
                                $display("FAIL done_pulse: got end=%b wb=%h count=%0d expected done=%b end=1 wb=%h count=%0d",
                                         bus.LSM_END, bus.WB_ADDR, bus.COUNT, e.done, e.wb, e.n);
                            end
                            void'(q.pop_front());
                        end
                    end
                end else begin
                    vectors++;
                    if (bus.LSM_END !== 1'b0) begin
                        fails++;
                        $display("FAIL idle_end: got LSM_END=%b expected 0", bus.LSM_END);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.START = 0; bus.STEP = 0; bus.REG_LIST = '0; bus.P_BIT = 0; bus.U_BIT = 0; bus.BASE = '0;
        RESET = 1;
        tick(); tick();
        chk_reset("reset");
        RESET = 0;
        bus.STEP = 1;
        tick(); tick();
        chk("step_in_idle_busy", 32'(bus.BUSY), 0);
        bus.STEP = 0;
        do_seq(16'h000B, 32'h100, 0, 1, 32'h100, 32'h10C, -1, 0);
        do_seq(16'h000B, 32'h100, 1, 0, 32'hF4, 32'hF4, -1, 0);
        do_seq(16'h000B, 32'h100, 1, 1, 32'h104, 32'h10C, -1, 0);
        do_seq(16'h000B, 32'h100, 0, 0, 32'hF8, 32'hF4, -1, 0);
        do_seq(16'h0000, 32'h200, 0, 1, 32'h200, 32'h200, -1, 0);
        do_seq(16'h0000, 32'h200, 1, 0, 32'h200, 32'h200, -1, 0);
        do_seq(16'hFFFF, 32'h0, 0, 1, 32'h0, 32'h40, 5, 0);
        do_seq(16'h0003, 32'hFFFF_FFFC, 0, 1, 32'hFFFF_FFFC, 32'h4, -1, 0);
        begin : reset_mid
            exp_t e;
            e.done = 0; e.r = 4; e.a = 32'h300; e.last = 0; e.wb = 32'h310; e.n = 4;
            q.push_back(e);
            e.r = 5; e.a = 32'h304;
            q.push_back(e);
            bus.REG_LIST = 16'h00F0; bus.BASE = 32'h300; bus.P_BIT = 0; bus.U_BIT = 1; bus.START = 1;
            tick();
            bus.START = 0; bus.STEP = 1;
            tick();
            bus.STEP = 0; RESET = 1;
            tick();
            chk_reset("mid_reset");
            RESET = 0;
            q.delete();
        end
        do_seq(16'h00F0, 32'h300, 0, 1, 32'h300, 32'h310, -1, 1);
        tick();
        chk("queue_drained", 32'(q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule

// File: doc/lsm_sequencer.md
Name: lsm_sequencer

Overview:
Sequences ARM load/store-multiple (LDM/STM) transfers for the microprogrammed control unit. It latches the 16-bit register list, base address and P/U mode bits, then walks the set bits from lowest to highest register. For each transfer it presents the register number and the word address. It drives LSM_DETECT and LSM_END into the control unit's next-state logic and advances on STEP, which the microcode issues after MOC.

Parameters:
ADDR_W, 32, address/base width
WORD_BYTES, 4, address increment per transfer

Ports:
CLK  input  1  system clock, all state changes on rising edge
RESET  input  1  synchronous, active-high reset
START  input  1  latch operands and begin sequence (honoured only in IDLE)
STEP  input  1  current transfer complete, advance (honoured only in ACTIVE)
REG_LIST  input  16  IR[15:0] register list
P_BIT  input  1  IR[24] pre/post index
U_BIT  input  1  IR[23] up/down
BASE  input  ADDR_W  base register value Rn
LSM_DETECT  output  1  sequence active and current register valid
LSM_END  output  1  current transfer is the last
REG_NUM  output  4  register number of current transfer
ADDR  output  ADDR_W  memory address of current transfer
WB_ADDR  output  ADDR_W  write-back value for Rn, valid from ACTIVE entry until next START
COUNT  output  5  number of registers in latched list (0..16)
BUSY  output  1  state != IDLE

Behaviour:
- Clock/reset: one clock CLK. Reset is synchronous and active-high on RESET; it overrides START/STEP in the same cycle.
- Reset values: state=IDLE, LSM_DETECT=0, LSM_END=0, REG_NUM=0, ADDR=0, WB_ADDR=0, COUNT=0, BUSY=0, pending list=0.
- FSM states:
  - IDLE: START=1 latches REG_LIST into pending, computes COUNT=popcount(REG_LIST), start address and WB_ADDR. Next state is ACTIVE if COUNT!=0, else DONE.
  - ACTIVE: LSM_DETECT=1, REG_NUM=index of lowest set bit of pending, LSM_END=(popcount(pending)==1). On STEP, the lowest set bit is cleared and ADDR+=WORD_BYTES. If LSM_END was 1, next state is DONE; else stay ACTIVE. Without STEP, all outputs hold.
  - DONE: one cycle; LSM_DETECT=0, LSM_END=1, BUSY=1; then IDLE.
- Latency: START edge to first valid REG_NUM/ADDR is 1 cycle. STEP edge to next register is 1 cycle (back-to-back STEP allowed, one transfer per cycle).
- Address rules (n=COUNT, all arithmetic mod 2^ADDR_W):
  - IA (P=0,U=1): start=BASE, WB=BASE+4n
  - IB (P=1,U=1): start=BASE+4, WB=BASE+4n
  - DA (P=0,U=0): start=BASE-4n+4, WB=BASE-4n
  - DB (P=1,U=0): start=BASE-4n, WB=BASE-4n
  - Addresses always ascend; the lowest register goes to the lowest address.
- Boundaries:
  - Empty list: no transfer; LSM_DETECT stays 0; DONE pulses LSM_END for one cycle; WB_ADDR=BASE.
  - START outside IDLE and STEP outside ACTIVE are ignored.
  - START and STEP in the same cycle: state-appropriate input wins, the other is ignored.
  - RESET mid-sequence returns to IDLE with reset values in one cycle; the pending list is discarded.
  - Address wrap past 0xFFFFFFFC wraps to 0 with no flag.
  - COUNT=16 (full list) must not overflow the 5-bit counter.

Optional Feature:
LSM_PC_FLAG_EN:
- Defined: adds output PC_IN_LIST (1 bit), latched at START as REG_LIST[15], held until next START, reset 0. Used by microcode to schedule pipeline flush after LDM with PC.
- Undefined: port and logic are absent; nothing else changes.

Decomposition:
- Shared package arm_cu_pkg: FSM state encodings (IDLE=2'd0, ACTIVE=2'd1, DONE=2'd2), P/U mode constants (IA/IB/DA/DB), WORD_BYTES default.
- One sub-module lsm_prio_enc: 16-bit lowest-set-bit encoder producing index[3:0] and valid. It is reused for REG_NUM and for clearing the current bit.
- Popcount stays inline.

Test Plan:
- IA: REG_LIST=0x000B, BASE=0x100, P=0,U=1, START, then STEP each cycle -> REG_NUM 0,1,3; ADDR 0x100,0x104,0x108; LSM_END only on R3; WB_ADDR=0x10C; DONE one cycle then BUSY=0.
- DB/IB/DA with same list and base:
  - DB -> ADDR 0xF4,0xF8,0xFC, WB 0xF4
  - IB -> 0x104,0x108,0x10C, WB 0x10C
  - DA -> 0xF8,0xFC,0x100, WB 0xF4
- Empty list REG_LIST=0x0000, START -> COUNT=0, LSM_DETECT never 1, LSM_END high exactly one cycle, WB_ADDR=BASE.
- Full list 0xFFFF IA BASE=0 -> COUNT=16, REG_NUM 0..15, last ADDR=0x3C, WB=0x40; STEP held low for 3 cycles mid-sequence -> outputs hold.
- Wrap: BASE=0xFFFFFFFC, list 0x0003, IA -> ADDR 0xFFFFFFFC then 0x00000000, WB 0x00000004.
- RESET asserted after first STEP of a 4-register list -> next cycle IDLE, all outputs 0. Fresh START works normally. START during ACTIVE is ignored (REG_NUM sequence unchanged).
